imm_ext_pipe: RTL and testbench
===============================

# imm_ext_pipe

Parametrised, registered immediate-extension stage for the pipelined MIPS datapath, the successor to the combinational 16→32 sign extender. It accepts an IN_W-bit immediate with a 2-bit mode over a valid/ready handshake. It produces an OUT_W-bit result one cycle later. A 2-entry skid buffer lets it sit between the decode and execute stages without a combinational ready path. It supports sign, zero, upper (LUI) and branch-offset (sign-extend then shift left by 2) extension, plus a synchronous flush for branch/exception squash.

## Interface
Parameters:
- IN_W, 16, immediate input width; legal range 2 to OUT_W-2
- OUT_W, 32, result width
- TAG_W, 5, sideband tag width (used only with EXT_TAG_EN)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous squash of all held entries
- in_valid  input  1  upstream has an immediate
- in_ready  output  1  stage can accept; registered, reset 0 during reset, 1 after
- in_imm  input  IN_W  raw immediate
- in_mode  input  2  0=SIGN, 1=ZERO, 2=UPPER, 3=BRANCH
- in_tag  input  TAG_W  sideband tag (EXT_TAG_EN only)
- out_valid  output  1  result available; reset 0
- out_ready  input  1  downstream accepts
- out_imm  output  OUT_W  extended result; reset 0
- out_tag  output  TAG_W  tag of out_imm; reset 0 (EXT_TAG_EN only)

## Operation
- Input transfer: in_valid & in_ready on a rising edge. Output transfer: out_valid & out_ready on a rising edge.
- Extension is computed on the input side and only the result is stored:
  - SIGN = {(OUT_W-IN_W){imm[IN_W-1]}, imm}
  - ZERO = {(OUT_W-IN_W){0}, imm}
  - UPPER = imm placed in the top IN_W bits, zeros below when OUT_W ≥ 2·IN_W; otherwise imm << (OUT_W-IN_W), truncated to OUT_W
  - BRANCH = SIGN result << 2, truncated to OUT_W
- Storage: main register (drives outputs) and skid register.
- State machine:
  - EMPTY: out_valid=0, in_ready=1. An input transfer loads main and moves to ONE.
  - ONE: out_valid=1, in_ready=1.
    - Input and output transfers together: main reloads, stay in ONE.
    - Input transfer only: load skid, go to TWO.
    - Output transfer only: go to EMPTY.
  - TWO: out_valid=1, in_ready=0. An output transfer moves skid to main and goes to ONE. in_valid is ignored.
- out_imm and out_tag hold steady while out_valid=1 and out_ready=0.
- Entries leave strictly in arrival order. None are dropped except by flush or reset.
- flush=1: next state EMPTY and out_valid=0 next cycle. Any input offered in the same cycle is discarded, even if in_ready=1. Stored data values are don't-care. Flush is identical to reset except that in_ready stays 1.
- Reset has priority over flush. Reset mid-transfer discards everything held.

## Timing
- Latency: an input transfer at edge N gives out_valid=1 with that result after edge N (a 1-cycle register stage).
- Throughput: 1 per cycle while out_ready=1.
- in_ready is a pure register output. It has no combinational path from out_ready.
- The in_* to out_* path always passes through a register.
- First cycle after reset deasserts: in_ready=1, out_valid=0.

## Configuration
- EXT_TAG_EN defined: in_tag/out_tag ports exist. The tag is stored alongside each entry and follows identical ordering and flush rules.
- EXT_TAG_EN undefined: tag ports and tag storage are absent, and TAG_W is unused.

## Structure
- Shared package imm_ext_pkg holds:
  - ext_mode_e enum: SIGN=2'd0, ZERO=2'd1, UPPER=2'd2, BRANCH=2'd3
  - skid state enum: EMPTY, ONE, TWO
- Sub-module imm_ext_core: the combinational mode-driven extender (parametrised IN_W/OUT_W), instantiated once on the input side.
- Elaboration-time check: IN_W ≤ OUT_W-2, otherwise fatal.

## Test plan
- Mode sweep, defaults, out_ready=1 (in_imm, in_mode → out_imm):
  - 16'h8000, SIGN → 32'hFFFF8000
  - 16'h8000, ZERO → 32'h00008000
  - 16'h1234, UPPER → 32'h12340000
  - 16'hFFFF, BRANCH → 32'hFFFFFFFC
  - each result appears one cycle after its input transfer
- Backpressure: out_ready=0, push 3 values in consecutive cycles → only 2 accepted. in_ready=0 after the second transfer. out_imm holds the first value. Release out_ready → values emerge in order, in_ready returns to 1.
- Streaming: 100 random inputs with out_ready=1 every cycle → 100 outputs, 1 per cycle, in order, all matching a reference model.
- Flush in state TWO together with in_valid=1 → next cycle out_valid=0, in_ready=1, nothing emerges later.
- Reset asserted mid-stream in state ONE → out_valid=0, out_imm=0, in_ready=0 while reset is high. After release, the first new input passes through normally.
- Parameter variant IN_W=12, OUT_W=32: 12'h800, SIGN → 32'hFFFFF800. UPPER → 32'h80000000. With EXT_TAG_EN, tag 5'd17 travels with its value.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared types for the registered immediate-extension stage.
// Holds the extension-mode encoding and the skid-buffer state encoding.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        SIGN   = 2'd0,
        ZERO   = 2'd1,
        UPPER  = 2'd2,
        BRANCH = 2'd3
    } ext_mode_e;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } skid_state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational mode-driven immediate extender (sign, zero, upper, branch offset).
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm_i,
    input  ext_mode_e        mode_i,
    output logic [OUT_W-1:0] ext_o
);

    logic [OUT_W-1:0] signExt;

    assign signExt = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};

    // UPPER is a left shift by OUT_W-IN_W, which also covers the OUT_W >= 2*IN_W case.
    always_comb begin
        ext_o = signExt;
        case (mode_i)
            SIGN:    ext_o = signExt;
            ZERO:    ext_o = {{(OUT_W-IN_W){1'b0}}, imm_i};
            UPPER:   ext_o = {imm_i, {(OUT_W-IN_W){1'b0}}};
            BRANCH:  ext_o = {signExt[OUT_W-3:0], 2'b00};
            default: ext_o = signExt;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage with a 2-entry skid buffer and synchronous flush.
// Optional sideband tag storage is enabled by defining EXT_TAG_EN.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm
`ifdef EXT_TAG_EN
    ,
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] out_tag
`endif
);

    if (IN_W < 2 || IN_W > OUT_W - 2 || TAG_W < 1) begin : g_param_check
        $fatal(1, "imm_ext_pipe: illegal parameters IN_W=%0d OUT_W=%0d TAG_W=%0d", IN_W, OUT_W, TAG_W);
    end

    skid_state_e      stateQ, stateD;
    logic             inReadyQ;
    logic [OUT_W-1:0] mainQ, skidQ;
    logic [OUT_W-1:0] extVal;
    logic             inXfer, outXfer;
    logic             loadMain, loadSkid, moveSkid;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm_i  (in_imm),
        .mode_i (ext_mode_e'(in_mode)),
        .ext_o  (extVal)
    );

    assign in_ready  = inReadyQ;
    assign out_valid = (stateQ != EMPTY);
    assign out_imm   = mainQ;
    assign inXfer    = in_valid & inReadyQ;
    assign outXfer   = out_valid & out_ready;

    always_comb begin
        stateD   = stateQ;
        loadMain = 1'b0;
        loadSkid = 1'b0;
        moveSkid = 1'b0;
        case (stateQ)
            EMPTY: begin
                if (inXfer) begin
                    loadMain = 1'b1;
                    stateD   = ONE;
                end
            end
            ONE: begin
                if (inXfer && outXfer) begin
                    loadMain = 1'b1;
                end else if (inXfer) begin
                    loadSkid = 1'b1;
                    stateD   = TWO;
                end else if (outXfer) begin
                    stateD = EMPTY;
                end
            end
            TWO: begin
                if (outXfer) begin
                    moveSkid = 1'b1;
                    stateD   = ONE;
                end
            end
            default: stateD = EMPTY;
        endcase
        // A squashed cycle discards both the held entries and anything offered now.
        if (flush) begin
            stateD   = EMPTY;
            loadMain = 1'b0;
            loadSkid = 1'b0;
            moveSkid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ   <= EMPTY;
            inReadyQ <= 1'b0;
            mainQ    <= '0;
        end else begin
            stateQ   <= stateD;
            inReadyQ <= (stateD != TWO);
            if (loadMain) begin
                mainQ <= extVal;
            end else if (moveSkid) begin
                mainQ <= skidQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (loadSkid) begin
            skidQ <= extVal;
        end
    end

`ifdef EXT_TAG_EN
    logic [TAG_W-1:0] mainTagQ, skidTagQ;

    assign out_tag = mainTagQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            mainTagQ <= '0;
        end else if (loadMain) begin
            mainTagQ <= in_tag;
        end else if (moveSkid) begin
            mainTagQ <= skidTagQ;
        end
    end

    always_ff @(posedge clk) begin
        if (loadSkid) begin
            skidTagQ <= in_tag;
        end
    end
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed mode/boundary scenarios plus a randomized
// stream compared against a FIFO-style reference model; tags are checked when EXT_TAG_EN is defined.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        inValid, inReady, outValid, outReady;
    logic [15:0] inImm;
    logic [1:0]  inMode;
    logic [31:0] outImm;
    logic [4:0]  inTag, outTag;

    logic        in12Valid, in12Ready, out12Valid, out12Ready;
    logic [11:0] in12Imm;
    logic [1:0]  in12Mode;
    logic [31:0] out12Imm;
    logic [4:0]  in12Tag, out12Tag;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] expQ[$];
    logic [4:0]  tagQ[$];
    bit          readyM = 1'b0;

    always #5 clk = ~clk;

    imm_ext_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_imm    (inImm),
        .in_mode   (inMode),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_imm   (outImm)
`ifdef EXT_TAG_EN
        ,
        .in_tag    (inTag),
        .out_tag   (outTag)
`endif
    );

    imm_ext_pipe #(.IN_W(12), .OUT_W(32)) dut12 (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .in_valid  (in12Valid),
        .in_ready  (in12Ready),
        .in_imm    (in12Imm),
        .in_mode   (in12Mode),
        .out_valid (out12Valid),
        .out_ready (out12Ready),
        .out_imm   (out12Imm)
`ifdef EXT_TAG_EN
        ,
        .in_tag    (in12Tag),
        .out_tag   (out12Tag)
`endif
    );

    // Extension rules expressed as plain integer arithmetic on a 64-bit value.
    function automatic logic [31:0] refExt(input int inW, input logic [31:0] raw, input logic [1:0] mode);
        longint u, s, r;
        u = longint'(raw) & ((longint'(1) << inW) - 1);
        s = (u >= (longint'(1) << (inW - 1))) ? u - (longint'(1) << inW) : u;
        case (mode)
            2'd0:    r = s;
            2'd1:    r = u;
            2'd2:    r = u * (longint'(1) << (32 - inW));
            default: r = s * 4;
        endcase
        return r[31:0];
    endfunction

    // Drives one cycle of stimulus and advances the 2-deep in-order queue model.
    task automatic tick(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                        input logic [4:0] tag, input logic ordy, input logic fl);
        bit acc, pop;
        inValid  = v;
        inImm    = imm;
        inMode   = mode;
        inTag    = tag;
        outReady = ordy;
        flush    = fl;
        acc = v && readyM && (expQ.size() < 2);
        pop = (expQ.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (reset) begin
            expQ.delete();
            tagQ.delete();
            readyM = 1'b0;
        end else if (fl) begin
            expQ.delete();
            tagQ.delete();
            readyM = 1'b1;
        end else begin
            if (pop) begin
                void'(expQ.pop_front());
                void'(tagQ.pop_front());
            end
            if (acc) begin
                expQ.push_back(refExt(16, {16'd0, imm}, mode));
                tagQ.push_back(tag);
            end
            readyM = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(1'b0, 16'd0, 2'd0, 5'd0, 1'b0, 1'b0);
        tick(1'b0, 16'd0, 2'd0, 5'd0, 1'b0, 1'b0);
        checkCount++;
        if (outValid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid);
        else passCount++;
        checkCount++;
        if (inReady !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b expected 0", inReady);
        else passCount++;
        checkCount++;
        if (outImm !== 32'd0) $display("[TB] FAIL reset_out_imm: got %h expected 0", outImm);
        else passCount++;
        reset = 1'b0;
        tick(1'b0, 16'd0, 2'd0, 5'd0, 1'b0, 1'b0);
        checkCount++;
        if (inReady !== 1'b1 || outValid !== 1'b0)
            $display("[TB] FAIL post_reset: got ready=%b valid=%b expected ready=1 valid=0", inReady, outValid);
        else passCount++;
    endtask

    task automatic test_modes();
        logic [15:0] imms[4] = '{16'h8000, 16'h8000, 16'h1234, 16'hFFFF};
        logic [31:0] exps[4] = '{32'hFFFF8000, 32'h00008000, 32'h12340000, 32'hFFFFFFFC};
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, imms[i], 2'(i), 5'(i), 1'b1, 1'b0);
            checkCount++;
            if (outValid !== 1'b1 || outImm !== exps[i])
                $display("[TB] FAIL mode_%0d: got valid=%b imm=%h expected valid=1 imm=%h", i, outValid, outImm, exps[i]);
            else passCount++;
        end
        tick(1'b0, 16'd0, 2'd0, 5'd0, 1'b1, 1'b0);
        checkCount++;
        if (outValid !== 1'b0) $display("[TB] FAIL mode_drain: got valid=%b expected 0", outValid);
        else passCount++;
    endtask

    task automatic test_backpressure();
        logic [15:0] vals[3] = '{16'h0011, 16'h8022, 16'h0033};
        logic [31:0] first, second;
        first  = refExt(16, {16'd0, vals[0]}, 2'd0);
        second = refExt(16, {16'd0, vals[1]}, 2'd0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, vals[i], 2'd0, 5'd0, 1'b0, 1'b0);
            checkCount++;
            if (outImm !== first || outValid !== 1'b1)
                $display("[TB] FAIL bp_hold_%0d: got valid=%b imm=%h expected valid=1 imm=%h", i, outValid, outImm, first);
            else passCount++;
            checkCount++;
            if (inReady !== (i == 0))
                $display("[TB] FAIL bp_ready_%0d: got %b expected %b", i, inReady, (i == 0));
            else passCount++;
        end
        tick(1'b0, 16'd0, 2'd0, 5'd0, 1'b1, 1'b0);
        checkCount++;
        if (outValid !== 1'b1 || outImm !== second || inReady !== 1'b1)
            $display("[TB] FAIL bp_release: got valid=%b imm=%h ready=%b expected 1 %h 1", outValid, outImm, inReady, second);
        else passCount++;
        tick(1'b0, 16'd0, 2'd0, 5'd0, 1'b1, 1'b0);
        checkCount++;
        if (outValid !== 1'b0) $display("[TB] FAIL bp_drain: got valid=%b expected 0 (third value leaked)", outValid);
        else passCount++;
    endtask

    task automatic test_streaming();
        int outCount = 0;
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [4:0]  tag;
        logic [31:0] want;
        for (int i = 0; i < 100; i++) begin
            imm  = 16'($urandom);
            mode = 2'($urandom_range(0, 3));
            tag  = 5'($urandom);
            want = refExt(16, {16'd0, imm}, mode);
            tick(1'b1, imm, mode, tag, 1'b1, 1'b0);
            if (outValid === 1'b1) outCount++;
            checkCount++;
            if (outValid !== 1'b1 || outImm !== want || expQ.size() != 1 || expQ[0] !== want)
                $display("[TB] FAIL stream_%0d: got valid=%b imm=%h expected valid=1 imm=%h", i, outValid, outImm, want);
            else passCount++;
`ifdef EXT_TAG_EN
            checkCount++;
            if (outTag !== tag) $display("[TB] FAIL stream_tag_%0d: got %0d expected %0d", i, outTag, tag);
            else passCount++;
`endif
        end
        checkCount++;
        if (outCount != 100) $display("[TB] FAIL stream_count: got %0d expected 100", outCount);
        else passCount++;
        tick(1'b0, 16'd0, 2'd0, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        tick(1'b1, 16'h0101, 2'd1, 5'd1, 1'b0, 1'b0);
        tick(1'b1, 16'h0202, 2'd1, 5'd2, 1'b0, 1'b0);
        checkCount++;
        if (inReady !== 1'b0 || outValid !== 1'b1)
            $display("[TB] FAIL flush_setup: got ready=%b valid=%b expected 0 1", inReady, outValid);
        else passCount++;
        tick(1'b1, 16'h0303, 2'd1, 5'd3, 1'b0, 1'b1);
        checkCount++;
        if (outValid !== 1'b0 || inReady !== 1'b1)
            $display("[TB] FAIL flush_state: got valid=%b ready=%b expected 0 1", outValid, inReady);
        else passCount++;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 16'd0, 2'd0, 5'd0, 1'b1, 1'b0);
            checkCount++;
            if (outValid !== 1'b0) $display("[TB] FAIL flush_after_%0d: got valid=%b expected 0", i, outValid);
            else passCount++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] want;
        tick(1'b1, 16'h7777, 2'd0, 5'd4, 1'b0, 1'b0);
        reset = 1'b1;
        tick(1'b0, 16'd0, 2'd0, 5'd0, 1'b0, 1'b0);
        checkCount++;
        if (outValid !== 1'b0 || outImm !== 32'd0 || inReady !== 1'b0)
            $display("[TB] FAIL midreset: got valid=%b imm=%h ready=%b expected 0 0 0", outValid, outImm, inReady);
        else passCount++;
        reset = 1'b0;
        tick(1'b0, 16'd0, 2'd0, 5'd0, 1'b1, 1'b0);
        checkCount++;
        if (inReady !== 1'b1 || outValid !== 1'b0)
            $display("[TB] FAIL midreset_release: got ready=%b valid=%b expected 1 0", inReady, outValid);
        else passCount++;
        want = refExt(16, 32'h0000C001, 2'd3);
        tick(1'b1, 16'hC001, 2'd3, 5'd5, 1'b1, 1'b0);
        checkCount++;
        if (outValid !== 1'b1 || outImm !== want)
            $display("[TB] FAIL midreset_first: got valid=%b imm=%h expected 1 %h", outValid, outImm, want);
        else passCount++;
        tick(1'b0, 16'd0, 2'd0, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic test_param12();
        in12Valid  = 1'b1;
        in12Imm    = 12'h800;
        in12Mode   = 2'd0;
        in12Tag    = 5'd17;
        out12Ready = 1'b1;
        @(posedge clk);
        #1;
        checkCount++;
        if (out12Valid !== 1'b1 || out12Imm !== 32'hFFFFF800)
            $display("[TB] FAIL p12_sign: got valid=%b imm=%h expected 1 FFFFF800", out12Valid, out12Imm);
        else passCount++;
`ifdef EXT_TAG_EN
        checkCount++;
        if (out12Tag !== 5'd17) $display("[TB] FAIL p12_tag: got %0d expected 17", out12Tag);
        else passCount++;
`endif
        in12Mode = 2'd2;
        in12Tag  = 5'd3;
        @(posedge clk);
        #1;
        checkCount++;
        if (out12Valid !== 1'b1 || out12Imm !== 32'h80000000)
            $display("[TB] FAIL p12_upper: got valid=%b imm=%h expected 1 80000000", out12Valid, out12Imm);
        else passCount++;
        in12Valid = 1'b0;
        @(posedge clk);
        #1;
        checkCount++;
        if (out12Valid !== 1'b0) $display("[TB] FAIL p12_drain: got valid=%b expected 0", out12Valid);
        else passCount++;
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        inValid    = 1'b0;
        inImm      = '0;
        inMode     = '0;
        inTag      = '0;
        outReady   = 1'b0;
        in12Valid  = 1'b0;
        in12Imm    = '0;
        in12Mode   = '0;
        in12Tag    = '0;
        out12Ready = 1'b0;
        #1;
        test_reset();
        test_modes();
        test_backpressure();
        test_streaming();
        test_flush();
        test_reset_mid();
        test_param12();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
